// File: rtl/nn_layer_pkg.sv
// nn_layer_pkg: shared types and arithmetic helpers for the RAM-backed
// neural-network layer MAC.
//   act_mode_e : activation selector (linear / ReLU / leaky / linear)
//   state_e    : sequencer states
//   activate() : activation applied to the wide accumulator value
//   saturate() : clamp to a signed range of a given word width
// Helpers work on a fixed 64-bit signed carrier so that callers with
// different accumulator widths can share them.
package nn_layer_pkg;

  typedef enum logic [1:0] {
    ACT_LINEAR     = 2'd0,
    ACT_RELU       = 2'd1,
    ACT_LEAKY      = 2'd2,
    ACT_LINEAR_ALT = 2'd3
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAC     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

  // Cycles between the last MAC read and a settled accumulator:
  // RAM read, registered product, accumulate.
  localparam int unsigned DrainCycles = 3;

  localparam int unsigned WideW = 64;
  typedef logic signed [WideW-1:0] wide_t;

  function automatic wide_t activate(input act_mode_e mode, input wide_t x);
    wide_t y;
    y = x;
    case (mode)
      ACT_RELU:  if (x < 0) y = '0;
      ACT_LEAKY: if (x < 0) y = x >>> 3;
      default:   y = x;
    endcase
    return y;
  endfunction

  function automatic wide_t saturate(input wide_t x, input int unsigned dw);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// nn_mac_lane: one MAC lane of the layer engine. Holds the weight bank for
// the neurons mapped to this lane, multiplies each weight with the shared
// activation, accumulates, and presents the activated + saturated result.
// Ports:
//   clk, reset_n           clock, async active-low reset (control + acc)
//   wgt_we/addr/data       weight bank write port (local address)
//   vld_p0, rd_addr_p0     read issue for the current index
//   bias_p0                current index is the bias word
//   x_p1                   activation word aligned with the bank read data
//   acc_clr                clear accumulator (pass start)
//   act_mode               activation selected for this run
//   result, clip           saturated lane output and clipping indicator
module nn_mac_lane
  import nn_layer_pkg::*;
#(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned FpWidth   = 4,
  parameter int unsigned AccW      = 18,
  parameter int unsigned BankDepth = 12,
  parameter int unsigned BankAW    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wgt_we,
  input  logic        [BankAW-1:0]    wgt_addr,
  input  logic signed [DataWidth-1:0] wgt_data,
  input  logic                        vld_p0,
  input  logic        [BankAW-1:0]    rd_addr_p0,
  input  logic                        bias_p0,
  input  logic signed [DataWidth-1:0] x_p1,
  input  logic                        acc_clr,
  input  act_mode_e                   act_mode,
  output logic signed [DataWidth-1:0] result,
  output logic                        clip
);

  logic signed [DataWidth-1:0]   bank [BankDepth];
  logic signed [DataWidth-1:0]   w_p1;
  logic                          vld_p1;
  logic                          bias_p1;
  logic signed [2*DataWidth-1:0] mul_p1;
  logic signed [2*DataWidth-1:0] mul_sh_p1;
  logic signed [AccW-1:0]        term_p2;
  logic                          vld_p2;
  logic signed [AccW-1:0]        acc;
  wide_t                         acc_w;
  wide_t                         act_w;
  wide_t                         sat_w;

  // p0 -> p1: weight bank read
  always_ff @(posedge clk) begin
    if (wgt_we) bank[wgt_addr] <= wgt_data;
    if (vld_p0) w_p1 <= bank[rd_addr_p0];
  end

  // p1 -> p2: registered product (fixed-point rescaled) or raw bias
  assign mul_p1    = (2*DataWidth)'(w_p1) * (2*DataWidth)'(x_p1);
  assign mul_sh_p1 = mul_p1 >>> FpWidth;

  always_ff @(posedge clk) begin
    term_p2 <= bias_p1 ? AccW'(w_p1) : AccW'(mul_sh_p1);
  end

  // p2 -> acc: accumulate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      bias_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      acc     <= '0;
    end else begin
      vld_p1  <= vld_p0;
      bias_p1 <= bias_p0;
      vld_p2  <= vld_p1;
      if (acc_clr)     acc <= '0;
      else if (vld_p2) acc <= acc + term_p2;
    end
  end

  always_comb begin
    acc_w = wide_t'(acc);
    act_w = activate(act_mode, acc_w);
    sat_w = saturate(act_w, DataWidth);
  end

  assign result = $signed(sat_w[DataWidth-1:0]);
  assign clip   = (sat_w != act_w);

endmodule

// File: rtl/ram_nn_layer_mac.sv
// ram_nn_layer_mac: computes one fully-connected layer from RAM-resident
// activations and weights using NumMacs parallel lanes, NumMacs neurons
// per pass, and writes saturated results out one word per cycle.
// Ports:
//   clk_i, reset_i                     clock, async active-low reset
//   req_i/ack_o                        upstream four-phase start handshake
//   req_o/ack_i                        downstream four-phase done handshake
//   act_mode_i                         activation, captured at start
//   in_we_i/in_addr_i/in_data_i        activation RAM load (idle only)
//   wgt_we_i/wgt_neuron_i/wgt_idx_i/
//   wgt_data_i                         weight load, idx NumInputs = bias
//   out_we_o/out_addr_o/out_data_o     result write port
//   busy_o                             engine not idle
//   ovf_o                              sticky saturation flag for the run
module ram_nn_layer_mac
  import nn_layer_pkg::*;
#(
  parameter  int unsigned NumInputs  = 10,
  parameter  int unsigned NumNeurons = 15,
  parameter  int unsigned NumMacs    = 4,
  parameter  int unsigned DataWidth  = 8,
  parameter  int unsigned FpWidth    = 4,
  localparam int unsigned InAddrW    = $clog2(NumInputs),
  localparam int unsigned OutAddrW   = $clog2(NumNeurons),
  localparam int unsigned IdxW       = $clog2(NumInputs + 1),
  localparam int unsigned AccW       = 2 * DataWidth + IdxW
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        req_i,
  output logic                        ack_o,
  output logic                        req_o,
  input  logic                        ack_i,
  input  logic [1:0]                  act_mode_i,
  input  logic                        in_we_i,
  input  logic [InAddrW-1:0]          in_addr_i,
  input  logic signed [DataWidth-1:0] in_data_i,
  input  logic                        wgt_we_i,
  input  logic [OutAddrW-1:0]         wgt_neuron_i,
  input  logic [IdxW-1:0]             wgt_idx_i,
  input  logic signed [DataWidth-1:0] wgt_data_i,
  output logic                        out_we_o,
  output logic [OutAddrW-1:0]         out_addr_o,
  output logic signed [DataWidth-1:0] out_data_o,
  output logic                        busy_o,
  output logic                        ovf_o
);

  localparam int unsigned NumPasses = (NumNeurons + NumMacs - 1) / NumMacs;
  localparam int unsigned PassW     = (NumPasses > 1) ? $clog2(NumPasses) : 1;
  localparam int unsigned LaneW     = (NumMacs > 1) ? $clog2(NumMacs) : 1;
  localparam int unsigned BankDepth = NumPasses * (NumInputs + 1);
  localparam int unsigned BankAW    = (BankDepth > 1) ? $clog2(BankDepth) : 1;

  state_e                      state_q;
  logic [PassW-1:0]            pass_q;
  logic [IdxW-1:0]             idx_q;
  logic [1:0]                  drain_q;
  logic [LaneW-1:0]            lane_q;
  act_mode_e                   mode_q;

  logic signed [DataWidth-1:0] in_ram [NumInputs];
  logic signed [DataWidth-1:0] x_p1;
  logic signed [DataWidth-1:0] lane_res [NumMacs];
  logic [NumMacs-1:0]          lane_clip;

  logic                        load_ok;
  logic                        vld_p0;
  logic                        bias_p0;
  logic [BankAW-1:0]           rd_addr_p0;
  logic [BankAW-1:0]           wgt_addr;
  logic                        wgt_ok;
  int                          wgt_bank;
  int                          valid_lanes;
  int                          next_lane;
  logic                        last_lane;
  logic                        more_passes;
  logic                        start;
  logic                        acc_clr;

  always_comb begin
    load_ok     = !busy_o;
    vld_p0      = (state_q == ST_MAC);
    bias_p0     = (int'(idx_q) == int'(NumInputs));
    rd_addr_p0  = BankAW'(int'(pass_q) * int'(NumInputs + 1) + int'(idx_q));
    // Neuron n lives in bank n % NumMacs at row n / NumMacs.
    wgt_bank    = int'(wgt_neuron_i) % int'(NumMacs);
    wgt_addr    = BankAW'((int'(wgt_neuron_i) / int'(NumMacs)) * int'(NumInputs + 1)
                          + int'(wgt_idx_i));
    wgt_ok      = wgt_we_i && load_ok && (int'(wgt_idx_i) <= int'(NumInputs))
                  && (int'(wgt_neuron_i) < int'(NumNeurons));
    // The final pass may cover fewer neurons than there are lanes.
    valid_lanes = int'(NumNeurons) - int'(pass_q) * int'(NumMacs);
    if (valid_lanes > int'(NumMacs)) valid_lanes = int'(NumMacs);
    next_lane   = int'(lane_q) + 1;
    last_lane   = (next_lane >= valid_lanes);
    more_passes = ((int'(pass_q) + 1) * int'(NumMacs) < int'(NumNeurons));
    start       = (state_q == ST_IDLE) && req_i;
    acc_clr     = start || ((state_q == ST_WRITE) && last_lane && more_passes);
  end

  // p0 -> p1: activation RAM read, aligned with the weight bank reads
  always_ff @(posedge clk_i) begin
    if (in_we_i && load_ok && (int'(in_addr_i) < int'(NumInputs)))
      in_ram[in_addr_i] <= in_data_i;
    if (vld_p0 && !bias_p0)
      x_p1 <= in_ram[idx_q[InAddrW-1:0]];
  end

  for (genvar l = 0; l < NumMacs; l++) begin : g_lane
    nn_mac_lane #(
      .DataWidth (DataWidth),
      .FpWidth   (FpWidth),
      .AccW      (AccW),
      .BankDepth (BankDepth),
      .BankAW    (BankAW)
    ) u_lane (
      .clk        (clk_i),
      .reset_n    (reset_i),
      .wgt_we     (wgt_ok && (wgt_bank == l)),
      .wgt_addr   (wgt_addr),
      .wgt_data   (wgt_data_i),
      .vld_p0     (vld_p0),
      .rd_addr_p0 (rd_addr_p0),
      .bias_p0    (bias_p0),
      .x_p1       (x_p1),
      .acc_clr    (acc_clr),
      .act_mode   (mode_q),
      .result     (lane_res[l]),
      .clip       (lane_clip[l])
    );
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      pass_q     <= '0;
      idx_q      <= '0;
      drain_q    <= '0;
      lane_q     <= '0;
      mode_q     <= ACT_LINEAR;
      req_o      <= 1'b0;
      ack_o      <= 1'b0;
      out_we_o   <= 1'b0;
      out_addr_o <= '0;
      out_data_o <= '0;
      busy_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            state_q <= ST_MAC;
            busy_o  <= 1'b1;
            ovf_o   <= 1'b0;
            mode_q  <= act_mode_e'(act_mode_i);
            pass_q  <= '0;
            idx_q   <= '0;
          end
        end
        ST_MAC: begin
          idx_q <= idx_q + IdxW'(1);
          if (bias_p0) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end
        ST_DRAIN: begin
          drain_q <= drain_q + 2'd1;
          // Accumulators settle on the previous edge; lane 0 goes out first.
          if (drain_q == 2'(DrainCycles - 1)) begin
            state_q    <= ST_WRITE;
            lane_q     <= '0;
            out_we_o   <= 1'b1;
            out_addr_o <= OutAddrW'(int'(pass_q) * int'(NumMacs));
            out_data_o <= lane_res[0];
            ovf_o      <= ovf_o | lane_clip[0];
          end
        end
        ST_WRITE: begin
          if (!last_lane) begin
            lane_q     <= LaneW'(next_lane);
            out_addr_o <= OutAddrW'(int'(pass_q) * int'(NumMacs) + next_lane);
            out_data_o <= lane_res[LaneW'(next_lane)];
            ovf_o      <= ovf_o | lane_clip[LaneW'(next_lane)];
          end else begin
            out_we_o <= 1'b0;
            if (more_passes) begin
              pass_q  <= pass_q + PassW'(1);
              idx_q   <= '0;
              state_q <= ST_MAC;
            end else begin
              state_q <= ST_DONE;
              req_o   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            req_o   <= 1'b0;
            ack_o   <= 1'b1;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!req_i) begin
            ack_o   <= 1'b0;
            busy_o  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_nn_layer_mac.sv
// Bench for ram_nn_layer_mac: directed layer scenarios plus randomized
// layers, all compared against a plain-arithmetic reference of the layer.
module tb_ram_nn_layer_mac;

  localparam int NI = 3;
  localparam int NN = 5;
  localparam int NM = 2;
  localparam int DW = 8;
  localparam int FP = 4;
  localparam int InAddrW  = 2;
  localparam int OutAddrW = 3;
  localparam int IdxW     = 2;

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 req_i = 1'b0;
  logic                 ack_o;
  logic                 req_o;
  logic                 ack_i = 1'b0;
  logic [1:0]           act_mode_i = 2'd0;
  logic                 in_we_i = 1'b0;
  logic [InAddrW-1:0]   in_addr_i = '0;
  logic signed [DW-1:0] in_data_i = '0;
  logic                 wgt_we_i = 1'b0;
  logic [OutAddrW-1:0]  wgt_neuron_i = '0;
  logic [IdxW-1:0]      wgt_idx_i = '0;
  logic signed [DW-1:0] wgt_data_i = '0;
  logic                 out_we_o;
  logic [OutAddrW-1:0]  out_addr_o;
  logic signed [DW-1:0] out_data_o;
  logic                 busy_o;
  logic                 ovf_o;

  always #5 clk = ~clk;

  ram_nn_layer_mac #(
    .NumInputs (NI), .NumNeurons (NN), .NumMacs (NM),
    .DataWidth (DW), .FpWidth (FP)
  ) dut (
    .clk_i (clk), .reset_i (reset_i),
    .req_i (req_i), .ack_o (ack_o), .req_o (req_o), .ack_i (ack_i),
    .act_mode_i (act_mode_i),
    .in_we_i (in_we_i), .in_addr_i (in_addr_i), .in_data_i (in_data_i),
    .wgt_we_i (wgt_we_i), .wgt_neuron_i (wgt_neuron_i),
    .wgt_idx_i (wgt_idx_i), .wgt_data_i (wgt_data_i),
    .out_we_o (out_we_o), .out_addr_o (out_addr_o), .out_data_o (out_data_o),
    .busy_o (busy_o), .ovf_o (ovf_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference layer contents.
  int x_m [NI];
  int w_m [NN][NI+1];

  // Write log gathered from the result port.
  int wq_addr [$];
  int wq_data [$];

  always @(negedge clk) begin
    if (out_we_o) begin
      wq_addr.push_back(int'(out_addr_o));
      wq_data.push_back(int'(out_data_o));
    end
  end

  // Neuron value after activation, before clamping to the output word.
  function automatic int ref_neuron(input int n, input int mode);
    int acc;
    acc = 0;
    for (int i = 0; i < NI; i++) acc += (w_m[n][i] * x_m[i]) >>> FP;
    acc += w_m[n][NI];
    if (mode == 1 && acc < 0) acc = 0;
    else if (mode == 2 && acc < 0) acc = acc >>> 3;
    return acc;
  endfunction

  function automatic int clamp_word(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int wr_data_at(input int k);
    if (k < wq_data.size()) return wq_data[k];
    return -9999;
  endfunction

  task automatic load_all();
    for (int i = 0; i < NI; i++) begin
      @(negedge clk);
      in_we_i = 1'b1; in_addr_i = i[InAddrW-1:0]; in_data_i = x_m[i][DW-1:0];
    end
    @(negedge clk);
    in_we_i = 1'b0;
    for (int n = 0; n < NN; n++) begin
      for (int j = 0; j <= NI; j++) begin
        wgt_we_i = 1'b1; wgt_neuron_i = n[OutAddrW-1:0];
        wgt_idx_i = j[IdxW-1:0]; wgt_data_i = w_m[n][j][DW-1:0];
        @(negedge clk);
      end
    end
    wgt_we_i = 1'b0;
  endtask

  task automatic run_layer(input int mode, input bit poke, input string tag);
    int  cyc, t_busy, t_req, held, e, r;
    bit  clip_any;
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    act_mode_i = mode[1:0];
    req_i = 1'b1;
    cyc = 0; t_busy = -1; t_req = -1;
    while (t_req < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy_o && t_busy < 0) t_busy = cyc;
      if (req_o) t_req = cyc;
      if (poke && cyc == 3) begin
        in_we_i = 1'b1; in_addr_i = '0; in_data_i = 8'sh55;
        wgt_we_i = 1'b1; wgt_neuron_i = '0; wgt_idx_i = '0; wgt_data_i = 8'sh7f;
      end else begin
        in_we_i = 1'b0; wgt_we_i = 1'b0;
      end
    end
    in_we_i = 1'b0; wgt_we_i = 1'b0;
    if (t_req < 0) begin
      chk({tag, "_timeout"}, 0, 1);
      req_i = 1'b0;
      return;
    end
    chk({tag, "_latency"}, t_req - t_busy, 26);
    held = 0;
    repeat (4) begin
      @(negedge clk);
      if (req_o) held++;
    end
    chk({tag, "_req_hold"}, held, 4);
    ack_i = 1'b1;
    @(negedge clk);
    chk({tag, "_req_drop"}, int'(req_o), 0);
    chk({tag, "_ack_rise"}, int'(ack_o), 1);
    ack_i = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_hold"}, int'(ack_o), 1);
    req_i = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, int'(ack_o), 0);
    chk({tag, "_idle"}, int'(busy_o), 0);
    chk({tag, "_nwrites"}, wq_data.size(), NN);
    clip_any = 1'b0;
    for (int n = 0; n < NN; n++) begin
      r = ref_neuron(n, mode);
      e = clamp_word(r);
      if (e != r) clip_any = 1'b1;
      if (n < wq_data.size()) begin
        chk($sformatf("%s_addr%0d", tag, n), wq_addr[n], n);
        chk($sformatf("%s_data%0d", tag, n), wq_data[n], e);
      end
    end
    chk({tag, "_ovf"}, int'(ovf_o), int'(clip_any));
  endtask

  task automatic set_basic();
    x_m[0] = 16; x_m[1] = 32; x_m[2] = -16;
    for (int n = 0; n < NN; n++)
      for (int j = 0; j <= NI; j++) w_m[n][j] = int'($urandom_range(0, 40)) - 20;
    w_m[0][0] = 16;  w_m[0][1] = 16; w_m[0][2] = 16; w_m[0][3] = 0;
    w_m[1][0] = -16; w_m[1][1] = 0;  w_m[1][2] = 0;  w_m[1][3] = 0;
  endtask

  initial begin
    // Reset state
    #2 reset_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_req", int'(req_o), 0);
    chk("rst_ack", int'(ack_o), 0);
    chk("rst_we", int'(out_we_o), 0);
    chk("rst_addr", int'(out_addr_o), 0);
    chk("rst_data", int'(out_data_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    reset_i = 1'b1;

    // Basic linear, ReLU, leaky
    set_basic();
    load_all();
    run_layer(0, 1'b0, "basic");
    chk("basic_n0", wr_data_at(0), 32);
    chk("basic_n1", wr_data_at(1), -16);
    run_layer(1, 1'b0, "relu");
    chk("relu_n1", wr_data_at(1), 0);
    run_layer(2, 1'b0, "leaky");
    chk("leaky_n1", wr_data_at(1), -2);

    // Saturation, then a benign run clears the sticky flag
    x_m[0] = 127; x_m[1] = 127; x_m[2] = 127;
    w_m[2][0] = 127; w_m[2][1] = 127; w_m[2][2] = 127; w_m[2][3] = 0;
    load_all();
    run_layer(0, 1'b0, "sat");
    chk("sat_n2", wr_data_at(2), 127);
    chk("sat_ovf", int'(ovf_o), 1);
    set_basic();
    load_all();
    run_layer(3, 1'b0, "benign");
    chk("benign_ovf", int'(ovf_o), 0);

    // Loads while busy are dropped; a rerun reproduces the same results
    run_layer(0, 1'b1, "busywr");
    run_layer(0, 1'b0, "rerun");

    // Reset in the middle of MAC
    wq_addr.delete();
    wq_data.delete();
    @(negedge clk);
    act_mode_i = 2'd0;
    req_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_started", int'(busy_o), 1);
    #2 reset_i = 1'b0;
    #1;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_we", int'(out_we_o), 0);
    chk("abort_data", int'(out_data_o), 0);
    chk("abort_addr", int'(out_addr_o), 0);
    chk("abort_reqo", int'(req_o), 0);
    req_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_nwrites", wq_data.size(), 0);
    reset_i = 1'b1;
    run_layer(0, 1'b0, "after_rst");

    // Randomized layers
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NI; i++)
        x_m[i] = (it % 2 == 1) ? int'($urandom_range(0, 255)) - 128
                               : int'($urandom_range(0, 96)) - 48;
      for (int n = 0; n < NN; n++)
        for (int j = 0; j <= NI; j++)
          w_m[n][j] = (it % 2 == 1) ? int'($urandom_range(0, 255)) - 128
                                    : int'($urandom_range(0, 96)) - 48;
      load_all();
      run_layer(int'($urandom_range(0, 3)), 1'b0, $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_nn_layer_mac.md
RAM_NN_LAYER_MAC -- requirements
Module: ram_nn_layer_mac

Interface
REQ-001 Param NumInputs, 10, activations per neuron (bias excluded).
REQ-002 Param NumNeurons, 15, neurons in layer.
REQ-003 Param NumMacs, 4, parallel MAC lanes; SHALL be a power of two and <= NumNeurons.
REQ-004 Param DataWidth, 8, signed fixed-point word width.
REQ-005 Param FpWidth, 4, fraction bits.
REQ-006 Derived: InAddrW = $clog2(NumInputs); OutAddrW = $clog2(NumNeurons); IdxW = $clog2(NumInputs+1); AccW = 2*DataWidth + IdxW.
REQ-007 Ports, one clock; reset asynchronous, active-low:
- clk_i  in  1  clock.
- reset_i  in  1  async active-low reset.
- req_i / ack_o  in/out  1/1  upstream four-phase handshake.
- req_o / ack_i  out/in  1/1  downstream four-phase handshake.
- act_mode_i  in  2  0 linear, 1 ReLU, 2 leaky (x>>>3), 3 linear; sampled at start.
- in_we_i, in_addr_i, in_data_i  in  1/InAddrW/DataWidth  input-activation RAM load.
- wgt_we_i, wgt_neuron_i, wgt_idx_i, wgt_data_i  in  1/OutAddrW/IdxW/DataWidth  weight load; idx = NumInputs selects bias.
- out_we_o, out_addr_o, out_data_o  out  1/OutAddrW/DataWidth  result write port.
- busy_o  out  1  high outside IDLE.
- ovf_o  out  1  sticky saturation flag for the current run.

Function
REQ-008 Weights SHALL sit in NumMacs banks; neuron n goes to bank n%NumMacs, local address (n/NumMacs)*(NumInputs+1)+idx.
REQ-009 Load writes (in_we_i, wgt_we_i) SHALL be accepted only when busy_o=0; while busy they are ignored.
REQ-010 FSM states: IDLE, MAC, DRAIN, WRITE, DONE, RELEASE.
REQ-011 IDLE->MAC when req_i=1. Start clears ovf_o, latches act_mode_i and sets pass=0.
REQ-012 MAC: issue reads idx 0..NumInputs (bias last), one per cycle, to all lanes in parallel; lane L computes neuron pass*NumMacs+L.
REQ-013 Pipeline: RAM read 1 cycle, registered multiply 1 cycle, accumulate 1 cycle. DRAIN SHALL last 3 cycles, then ->WRITE.
REQ-014 Product: signed DataWidth x DataWidth, arithmetic shift right by FpWidth, sign-extended to AccW. Bias is sign-extended to AccW, unshifted. Accumulator is cleared at pass start.
REQ-015 Activation on AccW value, then saturate to signed DataWidth range [-2^(DW-1), 2^(DW-1)-1]. Any clipping sets ovf_o.
REQ-016 WRITE: one cycle per valid lane, ascending L, out_we_o=1. Lanes with neuron index >= NumNeurons SHALL be skipped with no write.
REQ-017 After WRITE, the FSM goes to MAC with pass+1 if more neurons remain, else to DONE.
REQ-018 Pass duration = (NumInputs+1) + 3 + valid-lane count cycles.
REQ-019 DONE: req_o=1 until ack_i=1, then ->RELEASE with req_o=0.
REQ-020 RELEASE: ack_o=1 until req_i=0, then ->IDLE with ack_o=0.
REQ-021 ack_i outside DONE and req_i outside IDLE/RELEASE SHALL be ignored.
REQ-022 ovf_o SHALL hold its value until the next start.

Reset
REQ-023 On reset_i=0, asynchronously: FSM=IDLE, pass=0, accumulators=0, req_o=0, ack_o=0, out_we_o=0, out_addr_o=0, out_data_o=0, busy_o=0, ovf_o=0.
REQ-024 Reset mid-run SHALL abort with no further writes. RAM contents are retained, not cleared.

Structure
REQ-025 Package nn_layer_pkg SHALL hold act_mode_e, the FSM state enum and the saturate/activation functions.
REQ-026 One sub-module, nn_mac_lane (weight bank, multiplier, accumulator, activation), SHALL be instantiated NumMacs times.

Verification
Bench parameters: NumInputs=3, NumNeurons=5, NumMacs=2, DW=8, FpWidth=4 (1.0 = 16).
REQ-027 Directed scenarios the bench SHALL cover:
- Basic: x=[16,32,-16]; n0 w=[16,16,16], b=0 -> out addr0=32. n1 w=[-16,0,0], b=0, linear -> addr1=-16.
- ReLU: same as n1 with act_mode=1 -> addr1=0. Leaky (mode 2) -> addr1=-2.
- Saturation: x=[127,127,127], n2 w=[127,127,127] -> addr2=127, ovf_o=1. Next run with benign data -> ovf_o=0.
- Partial pass: 5 neurons -> 3 passes; last pass writes only addr4. Total 3*7+5 = 26 cycles from start to DONE. req_o held 4 cycles until ack_i, then ack_o drops 1 cycle after req_i=0.
- Busy write: in_we_i during MAC -> RAM unchanged. Rerun gives identical outputs.
- Reset mid-MAC -> all outputs 0 immediately, no out_we_o. New req_i then produces correct results from retained RAM.
